// File: rtl/map_pkg.sv
// Shared types and constants for the lane map access scheduler.
// Map geometry, cell codes, scroll FSM states and requester tags.
package map_pkg;

  localparam int LANES   = 5;
  localparam int MAP_LEN = 87;
  localparam int ROW_W   = 7;
  localparam int LANE_W  = 3;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] CELL_EMPTY = 3'd0;
  localparam logic [STATE_W-1:0] CELL_WALL  = 3'd1;
  localparam logic [STATE_W-1:0] CELL_COIN  = 3'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    END   = 2'd3
  } scroll_state_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_COL  = 2'd1,
    TAG_RD   = 2'd2
  } req_tag_e;

  // A lane or row outside the map reads as a wall instead of touching the ROM.
  function automatic logic is_off_track(input logic [LANE_W-1:0] lane,
                                        input logic [ROW_W-1:0]  row);
    logic lane_bad;
    logic row_bad;
    lane_bad = (lane >= LANES[LANE_W-1:0]);
    row_bad  = (row >= MAP_LEN[ROW_W-1:0]);
    return lane_bad | row_bad;
  endfunction

endpackage

// File: rtl/map_row_wrap.sv
// Screen-relative to absolute row conversion: (row + scroll_pos) mod MAP_LEN,
// plus the off-track flag for the requested lane/row.
module map_row_wrap
  import map_pkg::*;
(
  input  logic [LANE_W-1:0] lane,
  input  logic [ROW_W-1:0]  row,
  input  logic [ROW_W-1:0]  scroll_pos,
  output logic [ROW_W-1:0]  abs_row,
  output logic              out_of_range
);

  localparam logic [ROW_W:0] LEN_EXT = MAP_LEN[ROW_W:0];

  logic [ROW_W:0] sum_s;
  logic [ROW_W:0] diff_s;

  // Both operands are below MAP_LEN for in-range requests, so one subtraction suffices.
  always_comb begin
    sum_s  = {1'b0, row} + {1'b0, scroll_pos};
    diff_s = sum_s - LEN_EXT;
    if (sum_s >= LEN_EXT) begin
      abs_row = diff_s[ROW_W-1:0];
    end else begin
      abs_row = sum_s[ROW_W-1:0];
    end
    out_of_range = is_off_track(lane, row);
  end

endmodule

// File: rtl/map_access_sched.sv
// Scroll sequencer plus two-requester arbiter for the single map ROM read port.
// Results return two cycles after the grant, tagged back to their requester.
module map_access_sched
  import map_pkg::*;
#(
  parameter int LOOP   = 1,
  parameter int STARVE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hold,
  input  logic               scroll_tick,
  input  logic               col_req,
  input  logic [LANE_W-1:0]  col_lane,
  input  logic [ROW_W-1:0]   col_row,
  output logic               col_gnt,
  output logic               col_valid,
  output logic [STATE_W-1:0] col_state,
  input  logic               rd_req,
  input  logic [LANE_W-1:0]  rd_lane,
  input  logic [ROW_W-1:0]   rd_row,
  output logic               rd_gnt,
  output logic               rd_valid,
  output logic [STATE_W-1:0] rd_state,
  output logic [LANE_W-1:0]  map_x,
  output logic [ROW_W-1:0]   map_y,
  input  logic [STATE_W-1:0] map_state,
  output logic [ROW_W-1:0]   scroll_pos,
  output logic               lap_done
);

  localparam int SC_W = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE);
  localparam logic [SC_W-1:0]  SC_ONE     = SC_W'(1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(MAP_LEN - 1);
  localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);

  scroll_state_e      state_q, state_d;
  logic [ROW_W-1:0]   pos_q, pos_d;
  logic               lap_q, lap_d;
  logic [SC_W-1:0]    starve_q, starve_d;
  req_tag_e           tag1_q, tag1_d, tag2_q, tag2_d;
  logic               oor1_q, oor1_d, oor2_q, oor2_d;
  logic [LANE_W-1:0]  map_x_q, map_x_d;
  logic [ROW_W-1:0]   map_y_q, map_y_d;
  logic               col_valid_q, col_valid_d, rd_valid_q, rd_valid_d;
  logic [STATE_W-1:0] col_state_q, col_state_d, rd_state_q, rd_state_d;

  logic               col_gnt_s, rd_gnt_s, any_gnt_s;
  logic [LANE_W-1:0]  sel_lane_s;
  logic [ROW_W-1:0]   sel_row_s;
  logic [ROW_W-1:0]   abs_row_s;
  logic               oor_s;
  logic [STATE_W-1:0] ret_code_s;

  // Scroll FSM next state; start overrides everything, hold beats tick.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    lap_d   = 1'b0;
    if (start) begin
      state_d = RUN;
      pos_d   = {ROW_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (hold) begin
            state_d = PAUSE;
          end else if (scroll_tick) begin
            if (pos_q == LAST_ROW) begin
              lap_d = 1'b1;
              if (LOOP != 0) begin
                pos_d = {ROW_W{1'b0}};
              end else begin
                state_d = END;
              end
            end else begin
              pos_d = pos_q + ROW_ONE;
            end
          end else begin
            state_d = RUN;
          end
        end
        PAUSE: begin
          if (!hold) begin
            state_d = RUN;
          end else begin
            state_d = PAUSE;
          end
        end
        END:     state_d = END;
        default: state_d = IDLE;
      endcase
    end
  end

  map_row_wrap u_wrap (
    .lane        (sel_lane_s),
    .row         (sel_row_s),
    .scroll_pos  (pos_q),
    .abs_row     (abs_row_s),
    .out_of_range(oor_s)
  );

  // Arbitration, address capture and the tagged return pipeline.
  always_comb begin
    rd_gnt_s  = rd_req && (!col_req || (starve_q >= STARVE_LIM));
    col_gnt_s = col_req && !rd_gnt_s;
    any_gnt_s = col_gnt_s || rd_gnt_s;

    if (!rd_req || rd_gnt_s) begin
      starve_d = {SC_W{1'b0}};
    end else if (col_gnt_s) begin
      starve_d = starve_q + SC_ONE;
    end else begin
      starve_d = starve_q;
    end

    if (col_gnt_s) begin
      sel_lane_s = col_lane;
      sel_row_s  = col_row;
      tag1_d     = TAG_COL;
    end else if (rd_gnt_s) begin
      sel_lane_s = rd_lane;
      sel_row_s  = rd_row;
      tag1_d     = TAG_RD;
    end else begin
      sel_lane_s = col_lane;
      sel_row_s  = col_row;
      tag1_d     = TAG_NONE;
    end

    oor1_d = any_gnt_s && oor_s;
    // Off-track grants leave the ROM address alone: no read is issued.
    if (any_gnt_s && !oor_s) begin
      map_x_d = sel_lane_s;
      map_y_d = abs_row_s;
    end else begin
      map_x_d = map_x_q;
      map_y_d = map_y_q;
    end

    tag2_d     = tag1_q;
    oor2_d     = oor1_q;
    ret_code_s = oor2_q ? CELL_WALL : map_state;

    col_valid_d = (tag2_q == TAG_COL);
    rd_valid_d  = (tag2_q == TAG_RD);
    col_state_d = col_valid_d ? ret_code_s : col_state_q;
    rd_state_d  = rd_valid_d ? ret_code_s : rd_state_q;
  end

  // All state and registered outputs; reset drops any in-flight results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pos_q       <= {ROW_W{1'b0}};
      lap_q       <= 1'b0;
      starve_q    <= {SC_W{1'b0}};
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
      oor1_q      <= 1'b0;
      oor2_q      <= 1'b0;
      map_x_q     <= {LANE_W{1'b0}};
      map_y_q     <= {ROW_W{1'b0}};
      col_valid_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      col_state_q <= {STATE_W{1'b0}};
      rd_state_q  <= {STATE_W{1'b0}};
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      lap_q       <= lap_d;
      starve_q    <= starve_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      oor1_q      <= oor1_d;
      oor2_q      <= oor2_d;
      map_x_q     <= map_x_d;
      map_y_q     <= map_y_d;
      col_valid_q <= col_valid_d;
      rd_valid_q  <= rd_valid_d;
      col_state_q <= col_state_d;
      rd_state_q  <= rd_state_d;
    end
  end

  assign col_gnt    = col_gnt_s;
  assign rd_gnt     = rd_gnt_s;
  assign col_valid  = col_valid_q;
  assign rd_valid   = rd_valid_q;
  assign col_state  = col_state_q;
  assign rd_state   = rd_state_q;
  assign map_x      = map_x_q;
  assign map_y      = map_y_q;
  assign scroll_pos = pos_q;
  assign lap_done   = lap_q;

endmodule

// File: tb/tb_map_access_sched.sv
// Randomized bench for map_access_sched against a queue-based reference model,
// with a second instance (LOOP=0) sharing the stimulus to cover the END state.
module tb_map_access_sched;

  logic       clk, rst_n, start, hold, scroll_tick;
  logic       col_req, rd_req;
  logic [2:0] col_lane, rd_lane;
  logic [6:0] col_row, rd_row;
  logic       col_gnt, col_valid, rd_gnt, rd_valid, lap_done;
  logic [2:0] col_state, rd_state, map_x, map_state;
  logic [6:0] map_y, scroll_pos;

  logic       u_col_gnt, u_col_valid, u_rd_gnt, u_rd_valid, u_lap_done;
  logic [2:0] u_col_state, u_rd_state, u_map_x, u_map_state;
  logic [6:0] u_map_y, u_scroll_pos;

  map_access_sched #(.LOOP(1), .STARVE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .scroll_tick(scroll_tick),
    .col_req(col_req), .col_lane(col_lane), .col_row(col_row), .col_gnt(col_gnt),
    .col_valid(col_valid), .col_state(col_state),
    .rd_req(rd_req), .rd_lane(rd_lane), .rd_row(rd_row), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_state(rd_state),
    .map_x(map_x), .map_y(map_y), .map_state(map_state),
    .scroll_pos(scroll_pos), .lap_done(lap_done)
  );

  map_access_sched #(.LOOP(0), .STARVE(4)) dut_noloop (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .scroll_tick(scroll_tick),
    .col_req(col_req), .col_lane(col_lane), .col_row(col_row), .col_gnt(u_col_gnt),
    .col_valid(u_col_valid), .col_state(u_col_state),
    .rd_req(rd_req), .rd_lane(rd_lane), .rd_row(rd_row), .rd_gnt(u_rd_gnt),
    .rd_valid(u_rd_valid), .rd_state(u_rd_state),
    .map_x(u_map_x), .map_y(u_map_y), .map_state(u_map_state),
    .scroll_pos(u_scroll_pos), .lap_done(u_lap_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Map contents: lane 2 is all coin, the others cycle through the three codes.
  function automatic logic [2:0] rom_cell(input logic [2:0] lane, input logic [6:0] row);
    int v;
    if (lane == 3'd2) return 3'd2;
    v = (int'(lane) * 5 + int'(row)) % 3;
    return v[2:0];
  endfunction

  always @(posedge clk) begin
    map_state   <= rom_cell(map_x, map_y);
    u_map_state <= rom_cell(u_map_x, u_map_y);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference model state
  typedef struct {
    int         due;
    int         tag;
    logic [2:0] code;
  } exp_t;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_END = 3;

  exp_t       pend[$];
  int         cyc = 0;
  int         m_st[2];
  int         m_pos[2];
  bit         m_lap[2];
  int         m_starve;
  int         last_gnt;
  logic [2:0] exp_mx, exp_cs, exp_rs;
  logic [6:0] exp_my;

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = S_IDLE; m_pos[i] = 0; m_lap[i] = 1'b0;
    end
    m_starve = 0;
    pend.delete();
    exp_mx = 3'd0; exp_my = 7'd0; exp_cs = 3'd0; exp_rs = 3'd0;
  endtask

  task automatic drive_idle();
    start = 1'b0; hold = 1'b0; scroll_tick = 1'b0;
    col_req = 1'b0; rd_req = 1'b0;
    col_lane = 3'd0; col_row = 7'd0; rd_lane = 3'd0; rd_row = 7'd0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_col_valid", col_valid, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_col_state", col_state, 0);
    check("rst_rd_state", rd_state, 0);
    check("rst_map_x", map_x, 0);
    check("rst_map_y", map_y, 0);
    check("rst_scroll_pos", scroll_pos, 0);
    check("rst_lap_done", lap_done, 0);
    check("rst_noloop_pos", u_scroll_pos, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // One clock: check grants, advance the model, then check registered outputs.
  task automatic run_cycle();
    bit         eg_col, eg_rd, oor;
    logic [2:0] lane;
    logic [6:0] row;
    int         abs_row;
    bit         ev_col, ev_rd;
    exp_t       e;
    #1;
    eg_rd  = rd_req && (!col_req || m_starve >= 4);
    eg_col = col_req && !eg_rd;
    check("col_gnt", col_gnt, eg_col);
    check("rd_gnt", rd_gnt, eg_rd);
    last_gnt = eg_col ? 1 : (eg_rd ? 2 : 0);
    if (eg_col || eg_rd) begin
      lane    = eg_col ? col_lane : rd_lane;
      row     = eg_col ? col_row : rd_row;
      oor     = (lane >= 3'd5) || (row >= 7'd87);
      abs_row = (int'(row) + m_pos[0]) % 87;
      if (!oor) begin
        exp_mx = lane;
        exp_my = abs_row[6:0];
      end
      e.due  = cyc + 3;
      e.tag  = last_gnt;
      e.code = oor ? 3'd1 : rom_cell(lane, abs_row[6:0]);
      pend.push_back(e);
    end
    if (!rd_req || eg_rd) m_starve = 0;
    else if (eg_col) m_starve++;

    for (int i = 0; i < 2; i++) begin
      m_lap[i] = 1'b0;
      if (start) begin
        m_st[i] = S_RUN; m_pos[i] = 0;
      end else if (m_st[i] == S_RUN) begin
        if (hold) m_st[i] = S_PAUSE;
        else if (scroll_tick) begin
          if (m_pos[i] == 86) begin
            m_lap[i] = 1'b1;
            if (i == 0) m_pos[i] = 0;
            else m_st[i] = S_END;
          end else m_pos[i]++;
        end
      end else if (m_st[i] == S_PAUSE) begin
        if (!hold) m_st[i] = S_RUN;
      end
    end

    @(posedge clk);
    cyc++;
    #1;
    check("scroll_pos", scroll_pos, m_pos[0]);
    check("lap_done", lap_done, m_lap[0]);
    check("noloop_pos", u_scroll_pos, m_pos[1]);
    check("noloop_lap", u_lap_done, m_lap[1]);
    check("map_x", map_x, exp_mx);
    check("map_y", map_y, exp_my);
    ev_col = 1'b0; ev_rd = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      if (e.tag == 1) begin ev_col = 1'b1; exp_cs = e.code; end
      else begin ev_rd = 1'b1; exp_rs = e.code; end
    end
    check("col_valid", col_valid, ev_col);
    check("rd_valid", rd_valid, ev_rd);
    check("col_state", col_state, exp_cs);
    check("rd_state", rd_state, exp_rs);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    scroll_tick = 1'b1;
    for (int i = 0; i < n; i++) run_cycle();
    scroll_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  logic [6:0] saved_y;

  initial begin
    rst_n = 1'b0;
    model_clear();
    do_reset();

    // 1: start, three ticks, collision read of lane 0 row 10
    start = 1'b1; run_cycle(); start = 1'b0;
    ticks(3);
    check("t1_pos", scroll_pos, 3);
    col_req = 1'b1; col_lane = 3'd0; col_row = 7'd10;
    run_cycle();
    col_req = 1'b0;
    check("t1_map_y", map_y, 13);
    idle(3);

    // 2: wrapped address at scroll_pos 80, coin lane
    ticks(77);
    check("t2_pos", scroll_pos, 80);
    rd_req = 1'b1; rd_lane = 3'd2; rd_row = 7'd10;
    run_cycle();
    rd_req = 1'b0;
    check("t2_map_y", map_y, 3);
    idle(2);
    check("t2_rd_valid", rd_valid, 1);
    check("t2_rd_state", rd_state, 2);
    idle(1);

    // 3: both requesters held high -> COL x4, RD x1 repeating
    col_req = 1'b1; col_lane = 3'd1; col_row = 7'd5;
    rd_req = 1'b1; rd_lane = 3'd3; rd_row = 7'd7;
    for (int k = 0; k < 15; k++) begin
      run_cycle();
      check("t3_pattern", last_gnt, (k % 5 == 4) ? 2 : 1);
    end
    col_req = 1'b0; rd_req = 1'b0;
    idle(3);

    // 4: end of map, wrap vs stop
    ticks(6);
    check("t4_pos86", scroll_pos, 86);
    ticks(1);
    check("t4_wrap_pos", scroll_pos, 0);
    check("t4_lap", lap_done, 1);
    check("t4_noloop_pos", u_scroll_pos, 86);
    check("t4_noloop_lap", u_lap_done, 1);
    ticks(2);
    check("t4_lap_once", lap_done, 0);
    check("t4_noloop_held", u_scroll_pos, 86);

    // 5: off-track requests read as wall without touching the ROM
    saved_y = map_y;
    col_req = 1'b1; col_lane = 3'd5; col_row = 7'd0;
    run_cycle();
    col_req = 1'b0;
    check("t5_lane_map_y", map_y, saved_y);
    idle(2);
    check("t5_lane_valid", col_valid, 1);
    check("t5_lane_state", col_state, 1);
    col_req = 1'b1; col_lane = 3'd0; col_row = 7'd90;
    run_cycle();
    col_req = 1'b0;
    check("t5_row_map_y", map_y, saved_y);
    idle(2);
    check("t5_row_state", col_state, 1);

    // 6: hold beats tick; reset after a grant drops the result
    saved_y = scroll_pos;
    hold = 1'b1; scroll_tick = 1'b1;
    run_cycle();
    hold = 1'b0; scroll_tick = 1'b0;
    check("t6_hold_pos", scroll_pos, saved_y);
    run_cycle();
    rd_req = 1'b1; rd_lane = 3'd2; rd_row = 7'd1;
    run_cycle();
    rd_req = 1'b0;
    do_reset();
    idle(4);
    ticks(2);
    check("t6_idle_pos", scroll_pos, 0);

    // Random traffic
    start = 1'b1; run_cycle(); start = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      start       = ($urandom % 64) == 0;
      hold        = ($urandom % 8) == 0;
      scroll_tick = $urandom % 2;
      col_req     = $urandom % 2;
      rd_req      = $urandom % 2;
      col_lane    = 3'($urandom_range(0, 6));
      rd_lane     = 3'($urandom_range(0, 6));
      col_row     = 7'($urandom_range(0, 95));
      rd_row      = 7'($urandom_range(0, 95));
      run_cycle();
    end
    drive_idle();
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
